// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a + ~b + 1, one bit per clock, LSB first.
// A single full-adder cell plus shift registers; start/done handshake with borrow/overflow/zero flags.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic [WIDTH-2:0] res_sh;
   logic [CW-1:0]    count;
   logic             carry;

   logic             accept, last;
   logic             sum_bit, carry_nxt;
   logic [WIDTH-1:0] res_nxt;

   function automatic logic majority(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
   assign carry_nxt = majority(a_sh[0], b_sh[0], carry);
   assign res_nxt   = {sum_bit, res_sh};
   assign busy      = (state == RUN);

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (count == LAST) begin
               last      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         a_sh       <= '0;
         b_sh       <= '0;
         res_sh     <= '0;
         count      <= '0;
         carry      <= 1'b0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         overflow   <= 1'b0;
         zero       <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= last;
         if (accept) begin
            a_sh   <= a;
            b_sh   <= ~b;
            carry  <= 1'b1;
            res_sh <= '0;
            count  <= '0;
         end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            carry  <= carry_nxt;
            res_sh <= res_nxt[WIDTH-1:1];
            count  <= count + CW'(1);
            // On the last bit a_sh[0] is a's MSB and b_sh[0] is the inverted MSB of b,
            // so equal values here mean the operand signs differ.
            if (last) begin
               diff       <= res_nxt;
               borrow_out <= ~carry_nxt;
               overflow   <= (a_sh[0] == b_sh[0]) && (sum_bit != a_sh[0]);
               zero       <= (res_nxt == '0);
            end
         end
      end
   end

endmodule
